// File: rtl/ram_port_arbiter.sv
// Two-requester RAM port arbiter: an SPI command stream with a one-entry pending
// buffer and a host req/gnt port share one RAM port. Optional macro: ADDR_AUTOINC_EN.
module ram_port_arbiter #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int MEM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MEM_WIDTH+1:0] spi_rx_data,
  input  logic                 spi_rx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [MEM_WIDTH-1:0] host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [MEM_WIDTH-1:0] host_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [MEM_WIDTH-1:0] ram_wdata,
  input  logic [MEM_WIDTH-1:0] ram_rdata,
  output logic [MEM_WIDTH-1:0] tx_data,
  output logic                 tx_valid,
  output logic                 err_ovf
);

  typedef enum logic [1:0] {IDLE, SPI_ACC, HOST_ACC} state_t;
  typedef enum logic [1:0] {WR_ADDR = 2'b00, WR_DATA = 2'b01, RD_ADDR = 2'b10, RD_DATA = 2'b11} ctrl_t;
  typedef enum logic {GNT_HOST, GNT_SPI} grant_t;

  state_t state_q, state_d;
  grant_t last_grant_q;

  logic [ADDR_SIZE-1:0] wr_addr_q, rd_addr_q;
  logic                 pend_valid_q, pend_we_q;
  logic [ADDR_SIZE-1:0] pend_addr_q;
  logic [MEM_WIDTH-1:0] pend_data_q;
  logic                 cmd_we_q;
  logic [ADDR_SIZE-1:0] cmd_addr_q;
  logic [MEM_WIDTH-1:0] cmd_wdata_q;
  logic                 spi_rd_p1_q, host_rd_p1_q;

  ctrl_t                rx_ctrl;
  logic [MEM_WIDTH-1:0] rx_payload;
  logic                 host_act, pend_leaving, rx_mem, rx_accept, rx_drop;

  function automatic logic [ADDR_SIZE-1:0] to_addr(input logic [MEM_WIDTH-1:0] p);
    logic [31:0] w;
    w = 32'(p) % 32'(MEM_DEPTH);
    return ADDR_SIZE'(w);
  endfunction

`ifdef ADDR_AUTOINC_EN
  function automatic logic [ADDR_SIZE-1:0] inc_addr(input logic [ADDR_SIZE-1:0] a);
    return (a == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction
`endif

  assign rx_ctrl    = ctrl_t'(spi_rx_data[MEM_WIDTH+1 -: 2]);
  assign rx_payload = spi_rx_data[MEM_WIDTH-1:0];

  always_comb begin
    state_d  = IDLE;
    // The host request that is being granted this cycle must not win a second slot.
    host_act = host_req && (state_q != HOST_ACC);
    if (pend_valid_q && host_act)
      state_d = (last_grant_q == GNT_HOST) ? SPI_ACC : HOST_ACC;
    else if (pend_valid_q)
      state_d = SPI_ACC;
    else if (host_act)
      state_d = HOST_ACC;
    pend_leaving = (state_d == SPI_ACC);
    rx_mem       = spi_rx_valid && ((rx_ctrl == WR_DATA) || (rx_ctrl == RD_DATA));
    rx_accept    = rx_mem && (!pend_valid_q || pend_leaving);
    rx_drop      = rx_mem && !rx_accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_HOST;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == SPI_ACC) begin
        last_grant_q <= GNT_SPI;
        cmd_we_q     <= pend_we_q;
        cmd_addr_q   <= pend_addr_q;
        cmd_wdata_q  <= pend_data_q;
      end else if (state_d == HOST_ACC) begin
        last_grant_q <= GNT_HOST;
        cmd_we_q     <= host_we;
        cmd_addr_q   <= host_addr;
        cmd_wdata_q  <= host_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      err_ovf      <= 1'b0;
    end else begin
      if (spi_rx_valid && (rx_ctrl == WR_ADDR)) wr_addr_q <= to_addr(rx_payload);
      if (spi_rx_valid && (rx_ctrl == RD_ADDR)) rd_addr_q <= to_addr(rx_payload);
      if (rx_accept) begin
        pend_valid_q <= 1'b1;
        pend_we_q    <= (rx_ctrl == WR_DATA);
        pend_addr_q  <= (rx_ctrl == WR_DATA) ? wr_addr_q : rd_addr_q;
        pend_data_q  <= rx_payload;
`ifdef ADDR_AUTOINC_EN
        if (rx_ctrl == WR_DATA) wr_addr_q <= inc_addr(wr_addr_q);
        else                    rd_addr_q <= inc_addr(rd_addr_q);
`endif
      end else if (pend_leaving) begin
        pend_valid_q <= 1'b0;
      end
      if (rx_drop) err_ovf <= 1'b1;
    end
  end

  // Read return: flag in the cycle after the access, data captured one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_rd_p1_q  <= 1'b0;
      host_rd_p1_q <= 1'b0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      host_rvalid  <= 1'b0;
      host_rdata   <= '0;
    end else begin
      spi_rd_p1_q  <= (state_q == SPI_ACC) && !cmd_we_q;
      host_rd_p1_q <= (state_q == HOST_ACC) && !cmd_we_q;
      tx_valid     <= spi_rd_p1_q;
      host_rvalid  <= host_rd_p1_q;
      if (spi_rd_p1_q)  tx_data    <= ram_rdata;
      if (host_rd_p1_q) host_rdata <= ram_rdata;
    end
  end

  always_comb begin
    ram_en    = (state_q != IDLE);
    ram_we    = ram_en && cmd_we_q;
    ram_addr  = ram_en ? cmd_addr_q : '0;
    ram_wdata = ram_en ? cmd_wdata_q : '0;
    host_gnt  = (state_q == HOST_ACC);
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of RAM words.
REQ-002 SHALL have parameter ADDR_SIZE, default 8, RAM address width.
REQ-003 SHALL have parameter MEM_WIDTH, default 8, RAM data width.
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- spi_rx_data  in  MEM_WIDTH+2  SPI command; [MSB:MSB-1] = control (00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA), low bits = payload
- spi_rx_valid  in  1  spi_rx_data valid; one-cycle pulse, cannot be stalled
- host_req  in  1  host RAM request; held until host_gnt
- host_we  in  1  host write (1) / read (0)
- host_addr  in  ADDR_SIZE  host address
- host_wdata  in  MEM_WIDTH  host write data
- host_gnt  out  1  one-cycle grant; the host access is on the RAM port this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  MEM_WIDTH  host read data
- ram_en / ram_we  out  1 / 1  RAM enable / write enable
- ram_addr / ram_wdata  out  ADDR_SIZE / MEM_WIDTH  RAM address / write data
- ram_rdata  in  MEM_WIDTH  RAM read data, valid the cycle after a read is issued
- tx_data  out  MEM_WIDTH  SPI read response data
- tx_valid  out  1  SPI read response valid, one-cycle pulse
- err_ovf  out  1  sticky SPI pending-buffer overflow flag

Function
REQ-005 On WR_ADDR or RD_ADDR with spi_rx_valid, the block SHALL load the payload into wr_addr or rd_addr respectively at that edge; no RAM access.
REQ-006 On WR_DATA or RD_DATA with spi_rx_valid, the block SHALL load a one-entry pending register {we, addr (wr_addr or rd_addr as of that edge), data = payload}.
REQ-007 FSM states IDLE, SPI_ACC, HOST_ACC SHALL be registered; all RAM outputs and host_gnt SHALL be decoded from the state and its latched command only.
REQ-008 Next state SHALL be SPI_ACC if only pending is valid, HOST_ACC if only host_req is asserted (and host_gnt is not asserted this cycle), and IDLE if neither requests.
REQ-009 When both request, the block SHALL grant the requester not granted last; last_grant SHALL reset to HOST, so SPI wins the first conflict.
REQ-010 In SPI_ACC and HOST_ACC, ram_en SHALL be 1 and ram_we/ram_addr/ram_wdata SHALL equal the latched command; in IDLE all RAM outputs SHALL be 0.
REQ-011 host_gnt SHALL be 1 exactly in HOST_ACC; pending SHALL clear at entry to SPI_ACC unless reloaded at the same edge.
REQ-012 For a read, the block SHALL register ram_rdata one cycle after the access cycle and pulse tx_valid (SPI) or host_rvalid (host) in the following cycle with that data.
- Uncontested SPI RD_DATA accepted at edge k: ram_en in cycle k+1, tx_valid in cycle k+3.
REQ-013 If a memory command arrives while pending is valid and not leaving at the same edge, the new command SHALL be dropped and err_ovf SHALL set.
- Arrival at the same edge pending enters SPI_ACC: new command loads, no overflow.
REQ-014 tx_data and host_rdata SHALL hold their last value when not valid.
REQ-015 Address arithmetic SHALL be modulo MEM_DEPTH.

Reset
REQ-016 rst_n low SHALL asynchronously force state IDLE and clear all outputs, wr_addr, rd_addr, pending, last_grant (to HOST) and err_ovf.
REQ-017 A read in flight when reset asserts SHALL produce no tx_valid or host_rvalid after release.

Configuration
REQ-018 With ADDR_AUTOINC_EN defined, each accepted WR_DATA SHALL increment wr_addr and each accepted RD_DATA SHALL increment rd_addr at the accept edge, wrapping 255->0.
- Without the macro, wr_addr and rd_addr SHALL change only on WR_ADDR and RD_ADDR.

Verification
REQ-019 SPI WR_ADDR 0x12, then WR_DATA 0xA5 -> one cycle with ram_en=1, ram_we=1, ram_addr=0x12, ram_wdata=0xA5.
REQ-020 SPI RD_ADDR 0x12, then RD_DATA with RAM returning 0xA5 -> tx_valid pulse with tx_data=0xA5 three cycles after accept.
REQ-021 host_req read at 0x40 in the same cycle pending becomes valid (first conflict) -> SPI granted first, host_gnt next cycle, host_rvalid with RAM data two cycles after host_gnt.
REQ-022 Host held busy and SPI WR_DATA pulses on two consecutive cycles while SPI loses -> second dropped, err_ovf=1 until reset.
REQ-023 ADDR_AUTOINC_EN: WR_ADDR 0xFF then two WR_DATA -> ram_addr 0xFF then 0x00; without the macro, both at 0xFF.
REQ-024 rst_n low during the ram_en cycle of a read -> all outputs 0 immediately, no tx_valid after release.
